// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes the two issue lanes' memory ops onto the single
// dcache port in program order (lane 0 first). A req/ack handshake drives the
// dcache, and stall holds the pipeline until the whole bundle has completed.
// Optional store-to-load forwarding is enabled by defining MEM_FWD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lane0_read_ena,
    input  logic              i_lane0_write_ena,
    input  logic [ADDR_W-1:0] i_lane0_addr,
    input  logic [DATA_W-1:0] i_lane0_write_data,
    input  logic              i_lane1_read_ena,
    input  logic              i_lane1_write_ena,
    input  logic [ADDR_W-1:0] i_lane1_addr,
    input  logic [DATA_W-1:0] i_lane1_write_data,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_lane0_read_data,
    output logic [DATA_W-1:0] o_lane1_read_data,
    output logic              o_dc_req,
    output logic              o_dc_write,
    output logic [ADDR_W-1:0] o_dc_addr,
    output logic [DATA_W-1:0] o_dc_write_data,
    input  logic              i_dc_ack,
    input  logic [DATA_W-1:0] i_dc_read_data
);

    typedef enum logic [1:0] {StIdle, StReq0, StReq1, StDone} state_e;

    state_e              r_state, w_state_next;
    logic                r_dc_req, w_dc_req_next;
    logic                r_dc_write, w_dc_write_next;
    logic [ADDR_W-1:0]   r_dc_addr, w_dc_addr_next;
    logic [DATA_W-1:0]   r_dc_write_data, w_dc_write_data_next;
    logic [DATA_W-1:0]   r_rd0, w_rd0_next;
    logic [DATA_W-1:0]   r_rd1, w_rd1_next;

    logic w_l0_op, w_l1_op, w_fwd, w_stall;

    // A lane with both enables set is a store; the read is ignored.
    assign w_l0_op = i_lane0_read_ena | i_lane0_write_ena;
    assign w_l1_op = i_lane1_read_ena | i_lane1_write_ena;

`ifdef MEM_FWD_EN
    // Lane 1 loads the word lane 0 is storing: serve it from the store data.
    assign w_fwd = i_lane0_write_ena & i_lane1_read_ena & ~i_lane1_write_ena
                   & (i_lane0_addr == i_lane1_addr);
`else
    assign w_fwd = 1'b0;
`endif

    // Next-state, next request payload, read-data capture and stall.
    always_comb begin
        w_state_next         = r_state;
        w_dc_req_next        = r_dc_req;
        w_dc_write_next      = r_dc_write;
        w_dc_addr_next       = r_dc_addr;
        w_dc_write_data_next = r_dc_write_data;
        w_rd0_next           = r_rd0;
        w_rd1_next           = r_rd1;
        w_stall              = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_l0_op) begin
                    w_stall              = 1'b1;
                    w_state_next         = StReq0;
                    w_dc_req_next        = 1'b1;
                    w_dc_write_next      = i_lane0_write_ena;
                    w_dc_addr_next       = i_lane0_addr;
                    w_dc_write_data_next = i_lane0_write_data;
                end else if (w_l1_op) begin
                    w_stall              = 1'b1;
                    w_state_next         = StReq1;
                    w_dc_req_next        = 1'b1;
                    w_dc_write_next      = i_lane1_write_ena;
                    w_dc_addr_next       = i_lane1_addr;
                    w_dc_write_data_next = i_lane1_write_data;
                end
            end
            StReq0: begin
                w_stall = 1'b1;
                if (i_dc_ack) begin
                    if (!r_dc_write) begin
                        w_rd0_next = i_dc_read_data;
                    end
                    if (w_fwd) begin
                        w_rd1_next    = i_lane0_write_data;
                        w_state_next  = StDone;
                        w_dc_req_next = 1'b0;
                    end else if (w_l1_op) begin
                        // dc_req stays high; only the payload switches lanes.
                        w_state_next         = StReq1;
                        w_dc_write_next      = i_lane1_write_ena;
                        w_dc_addr_next       = i_lane1_addr;
                        w_dc_write_data_next = i_lane1_write_data;
                    end else begin
                        w_state_next  = StDone;
                        w_dc_req_next = 1'b0;
                    end
                end
            end
            StReq1: begin
                w_stall = 1'b1;
                if (i_dc_ack) begin
                    if (!r_dc_write) begin
                        w_rd1_next = i_dc_read_data;
                    end
                    w_state_next  = StDone;
                    w_dc_req_next = 1'b0;
                end
            end
            StDone: begin
                // Bundle advances this cycle; its requests are not re-examined.
                w_state_next = StIdle;
            end
            default: begin
                w_state_next  = StIdle;
                w_dc_req_next = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_dc_req        <= 1'b0;
            r_dc_write      <= 1'b0;
            r_dc_addr       <= '0;
            r_dc_write_data <= '0;
            r_rd0           <= '0;
            r_rd1           <= '0;
        end else begin
            r_state         <= w_state_next;
            r_dc_req        <= w_dc_req_next;
            r_dc_write      <= w_dc_write_next;
            r_dc_addr       <= w_dc_addr_next;
            r_dc_write_data <= w_dc_write_data_next;
            r_rd0           <= w_rd0_next;
            r_rd1           <= w_rd1_next;
        end
    end

    assign o_stall           = w_stall;
    assign o_dc_req          = r_dc_req;
    assign o_dc_write        = r_dc_write;
    assign o_dc_addr         = r_dc_addr;
    assign o_dc_write_data   = r_dc_write_data;
    assign o_lane0_read_data = r_rd0;
    assign o_lane1_read_data = r_rd1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized bundles, resets and dcache wait states checked every cycle
// against a queue-based model of the bundle's pending accesses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        l0r, l0w, l1r, l1w;
    logic [31:0] a0, d0, a1, d1;
    logic        dc_ack;
    logic [31:0] dc_rdata;
    logic        o_stall, o_dc_req, o_dc_write;
    logic [31:0] o_rd0, o_rd1, o_dc_addr, o_dc_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_lane0_read_ena   (l0r),
        .i_lane0_write_ena  (l0w),
        .i_lane0_addr       (a0),
        .i_lane0_write_data (d0),
        .i_lane1_read_ena   (l1r),
        .i_lane1_write_ena  (l1w),
        .i_lane1_addr       (a1),
        .i_lane1_write_data (d1),
        .o_stall            (o_stall),
        .o_lane0_read_data  (o_rd0),
        .o_lane1_read_data  (o_rd1),
        .o_dc_req           (o_dc_req),
        .o_dc_write         (o_dc_write),
        .o_dc_addr          (o_dc_addr),
        .o_dc_write_data    (o_dc_wdata),
        .i_dc_ack           (dc_ack),
        .i_dc_read_data     (dc_rdata)
    );

`ifdef MEM_FWD_EN
    localparam int FwdReqCycles   = 1;
    localparam int FwdStallCycles = 2;
`else
    localparam int FwdReqCycles   = 2;
    localparam int FwdStallCycles = 3;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // dcache contents (dmem) and the model's own view of memory (smem).
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dmem[a] = v;
        smem[a] = v;
    endtask

    // ---------------- dcache responder ----------------
    int   ack_delay   = 0;   // <0: random wait states
    bit   spurious_en = 1'b0;
    bit   ack_force   = 1'b0;
    int   age         = 0;
    logic was_req = 1'b0, consumed = 1'b0, was_rst = 1'b0;

    always @(negedge clk) begin
        was_req  = o_dc_req;
        consumed = o_dc_req & dc_ack;
        was_rst  = rst;
        if (o_dc_req && dc_ack && o_dc_write && !rst) dmem[o_dc_addr] = o_dc_wdata;
    end

    always @(posedge clk) begin
        #2;
        if (!o_dc_req || consumed || was_rst || !was_req) age = 0;
        else age++;
        if (ack_force) dc_ack = 1'b1;
        else if (o_dc_req) dc_ack = (ack_delay < 0) ? ($urandom_range(0, 2) == 0)
                                                    : (age >= ack_delay);
        else dc_ack = spurious_en && ($urandom_range(0, 7) == 0);
        dc_rdata = (o_dc_req && !o_dc_write) ? dmem_rd(o_dc_addr) : $urandom;
    end

    // ---------------- behavioural model + compare ----------------
    // The bundle is a queue of accesses still owed to the dcache; the head is
    // the one that must be on the port. One stall-free cycle follows its drain.
    typedef struct {
        logic        lane;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         q[$];
    op_t         m_h;
    bit          model_on  = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_fwd     = 1'b0;
    logic [31:0] m_fwd_val = '0;
    logic [31:0] m_rd0     = '0;
    logic [31:0] m_rd1     = '0;
    logic        m_any, m_exp_stall;

    always @(negedge clk) begin
        if (model_on) begin
            m_any = l0r | l0w | l1r | l1w;
            m_exp_stall = m_done ? 1'b0 : ((q.size() != 0) ? 1'b1 : m_any);
            chk("stall", 32'(o_stall), 32'(m_exp_stall));
            chk("dc_req", 32'(o_dc_req), 32'(q.size() != 0));
            if (q.size() != 0) begin
                m_h = q[0];
                chk("dc_write", 32'(o_dc_write), 32'(m_h.wr));
                chk("dc_addr", o_dc_addr, m_h.addr);
                chk("dc_write_data", o_dc_wdata, m_h.data);
            end
            chk("lane0_read_data", o_rd0, m_rd0);
            chk("lane1_read_data", o_rd1, m_rd1);
            // Advance the model across the coming clock edge.
            if (rst) begin
                q.delete();
                m_done = 1'b0;
                m_fwd  = 1'b0;
                m_rd0  = '0;
                m_rd1  = '0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (q.size() != 0) begin
                if (dc_ack) begin
                    m_h = q.pop_front();
                    if (m_h.wr) smem[m_h.addr] = m_h.data;
                    else if (m_h.lane) m_rd1 = smem_rd(m_h.addr);
                    else m_rd0 = smem_rd(m_h.addr);
                    if (q.size() == 0) begin
                        m_done = 1'b1;
                        if (m_fwd) begin
                            m_rd1 = m_fwd_val;
                            m_fwd = 1'b0;
                        end
                    end
                end
            end else if (m_any) begin
                if (l0r | l0w) q.push_back('{1'b0, l0w, a0, d0});
`ifdef MEM_FWD_EN
                if (l0w && l1r && !l1w && a0 == a1) begin
                    m_fwd     = 1'b1;
                    m_fwd_val = d0;
                end else
`endif
                if (l1r | l1w) q.push_back('{1'b1, l1w, a1, d1});
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_lanes();
        l0r = 0; l0w = 0; l1r = 0; l1w = 0;
    endtask

    // Entered just after a rising edge with the DUT idle; returns likewise.
    task automatic run_bundle(input logic r0, input logic w0, input logic [31:0] ad0,
                              input logic [31:0] dt0, input logic r1, input logic w1,
                              input logic [31:0] ad1, input logic [31:0] dt1,
                              output int n_stall, output int n_req,
                              output logic [31:0] first_addr, output logic [31:0] rd0v,
                              output logic [31:0] rd1v);
        bit seen, fin;
        n_stall = 0; n_req = 0; first_addr = '0; seen = 0; fin = 0;
        l0r = r0; l0w = w0; a0 = ad0; d0 = dt0;
        l1r = r1; l1w = w1; a1 = ad1; d1 = dt1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_dc_req && !seen) begin
                seen = 1;
                first_addr = o_dc_addr;
            end
            n_req += int'(o_dc_req);
            if (!o_stall) begin
                fin = 1;
                break;
            end
            n_stall++;
        end
        if (!fin) chk("bundle_timeout", 32'(fin), 32'd1);
        rd0v = o_rd0;
        rd1v = o_rd1;
        @(posedge clk); #1;
        clear_lanes();
    endtask

    logic [31:0] pool [4];
    int          ns, nr, k0, k1, ist, ireq;
    logic [31:0] fa, r0v, r1v;
    logic        ps;

    initial begin
        pool[0] = 32'h80; pool[1] = 32'h100; pool[2] = 32'h200; pool[3] = 32'h300;
        rst = 1; clear_lanes();
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        dc_ack = 0; dc_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_on = 1'b1;
        rst = 0;

        // Idle for 10 cycles.
        ist = 0; ireq = 0;
        repeat (10) begin
            @(negedge clk);
            ist += int'(o_stall);
            ireq += int'(o_dc_req);
        end
        chk("idle_stall_cycles", ist, 0);
        chk("idle_req_cycles", ireq, 0);
        chk("idle_rd0", o_rd0, 32'h0);
        chk("idle_rd1", o_rd1, 32'h0);
        @(posedge clk); #1;

        // Lane 0 load, zero-wait dcache.
        preload(32'h100, 32'hDEADBEEF);
        run_bundle(1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, ns, nr, fa, r0v, r1v);
        chk("ld0_stall_cycles", ns, 2);
        chk("ld0_req_cycles", nr, 1);
        chk("ld0_rd0", r0v, 32'hDEADBEEF);

        // Lane 0 store + lane 1 load, two wait states each.
        ack_delay = 2;
        preload(32'h300, 32'h33333333);
        run_bundle(0, 1, 32'h200, 32'h11111111, 1, 0, 32'h300, 32'h0, ns, nr, fa, r0v, r1v);
        chk("st_ld_stall_cycles", ns, 7);
        chk("st_ld_req_cycles", nr, 6);
        chk("st_ld_first_addr", fa, 32'h200);
        chk("st_ld_rd1", r1v, 32'h33333333);
        chk("st_ld_stored", dmem_rd(32'h200), 32'h11111111);

        // Lane 1 load only.
        ack_delay = 0;
        preload(32'h40, 32'h44444444);
        run_bundle(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, ns, nr, fa, r0v, r1v);
        chk("ld1_stall_cycles", ns, 2);
        chk("ld1_req_cycles", nr, 1);
        chk("ld1_first_addr", fa, 32'h40);
        chk("ld1_rd1", r1v, 32'h44444444);
        chk("ld1_rd0_held", r0v, 32'hDEADBEEF);

        // Store then load to the same word.
        preload(32'h80, 32'h0BADF00D);
        run_bundle(0, 1, 32'h80, 32'hCAFEF00D, 1, 0, 32'h80, 32'h0, ns, nr, fa, r0v, r1v);
        chk("fwd_req_cycles", nr, FwdReqCycles);
        chk("fwd_stall_cycles", ns, FwdStallCycles);
        chk("fwd_rd1", r1v, 32'hCAFEF00D);

        // Reset while in REQ1 with no ack; a late ack follows.
        ack_delay = 1000;
        l1r = 1; a1 = 32'h40;
        @(negedge clk);
        chk("rst_idle_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst_pre_req", 32'(o_dc_req), 32'd1);
        @(posedge clk); #1;
        rst = 0; clear_lanes(); ack_force = 1;
        @(negedge clk);
        chk("rst_dc_req", 32'(o_dc_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_rd0", o_rd0, 32'h0);
        chk("rst_rd1", o_rd1, 32'h0);
        @(posedge clk); #1;
        ack_force = 0;
        @(negedge clk);
        chk("late_ack_dc_req", 32'(o_dc_req), 32'd0);
        chk("late_ack_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;

        // Randomized bundles, wait states, spurious acks and resets.
        ack_delay = -1;
        spurious_en = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            ps = o_stall;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 59) == 0);
            if (!ps) begin
                k0 = int'($urandom_range(0, 3));
                k1 = int'($urandom_range(0, 3));
                l0r = k0[0]; l0w = k0[1];
                l1r = k1[0]; l1w = k1[1];
                a0 = pool[$urandom_range(0, 3)];
                a1 = pool[$urandom_range(0, 3)];
                d0 = $urandom;
                d1 = $urandom;
            end
        end
        rst = 0;
        repeat (20) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
